// File: rtl/seq_pkg.sv
// Shared constants for the serializer / sequence-detector slice.
// FSM encodings, default word width and the reference test pattern.
package seq_pkg;
    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  SHIFT     = 1'b1;
    localparam int          SER_WIDTH = 32;
    localparam logic [31:0] SEQ_PAT   = 32'h6DB4B255;
endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake into the serializer: valid/data from upstream, ready back.
// The master side offers words; the slave side registers ready with no path from valid.
interface piso_serializer_if #(
    parameter int WIDTH = 32
) ();
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (output load_valid, output load_data, input  load_ready);
    modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit position counter: clear to 0, start at 1, or increment; last flags WIDTH-1.
// Single-cycle update, no backpressure.
module piso_bit_counter #(
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          start,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);
    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = CW'(1);
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_POS);
endmodule

// File: rtl/piso_serializer.sv
// MSB-first word serializer with a one-word holding buffer; first bit 1 cycle after accept, gapless back-to-back.
// load_ready is a registered !hold_full: one word may queue while another shifts.
module piso_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave ld,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_start,
    output logic             word_done,
    output logic [CNT_W-1:0] words_sent
);
    localparam int CW = $clog2(WIDTH);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             load_ready_q, load_ready_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             word_start_q, word_start_d;
    logic             word_done_q, word_done_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;

    logic          accept;
    logic          cnt_clr, cnt_start, cnt_inc, cnt_last;
    logic [CW-1:0] cnt;

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .start (cnt_start),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    assign accept = ld.load_valid && load_ready_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        word_start_d = 1'b0;
        word_done_d  = 1'b0;
        words_sent_d = words_sent_q;
        cnt_clr      = 1'b0;
        cnt_start    = 1'b0;
        cnt_inc      = 1'b0;

        if (state_q == IDLE) begin
            if (accept) begin
                dout_d       = ld.load_data[WIDTH-1];
                dout_valid_d = 1'b1;
                word_start_d = 1'b1;
                shreg_d      = ld.load_data << 1;
                cnt_start    = 1'b1;
                state_d      = SHIFT;
            end else begin
                cnt_clr = 1'b1;
            end
        end else begin
            dout_valid_d = 1'b1;
            cnt_inc      = 1'b1;
            // cnt==0 in SHIFT is the first bit of a continuation word, sourced from hold if it is full
            if (cnt == '0) begin
                word_start_d = 1'b1;
                if (hold_full_q) begin
                    dout_d      = hold_q[WIDTH-1];
                    shreg_d     = hold_q << 1;
                    hold_full_d = 1'b0;
                end else begin
                    dout_d  = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end
            end else begin
                dout_d  = shreg_q[WIDTH-1];
                shreg_d = shreg_q << 1;
            end

            if (cnt_last) begin
                word_done_d  = 1'b1;
                words_sent_d = words_sent_q + CNT_W'(1);
                if (!hold_full_q) begin
                    if (accept) begin
                        shreg_d = ld.load_data;
                    end else begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                        cnt_inc = 1'b0;
                    end
                end
            end else if (accept) begin
                hold_d      = ld.load_data;
                hold_full_d = 1'b1;
            end
        end

        load_ready_d = !hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            word_start_q <= 1'b0;
            word_done_q  <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            load_ready_q <= load_ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_start_q <= word_start_d;
            word_done_q  <= word_done_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign ld.load_ready = load_ready_q;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign word_start    = word_start_q;
    assign word_done     = word_done_q;
    assign words_sent    = words_sent_q;
endmodule
